fan_pwm_ramp: RTL and testbench
===============================

Name: fan_pwm_ramp

Overview:
Downstream PWM stage of the fan speed path. Takes the 0..100 % duty target chosen by the fan speed selector and produces the fan/LED PWM output. Duty changes are glitch-free: a new duty takes effect only at a PWM period boundary. A soft-start/soft-stop ramp moves the applied duty 1 % at a time toward the target, so speed steps (0 → 30 → 60 → 90) never jump the motor.

Parameters:
SYS_FREQ, 100_000_000, clk frequency in Hz
PWM_FREQ, 10_000, PWM frequency in Hz; PERIOD = SYS_FREQ/PWM_FREQ clocks, must be a multiple of 100 and ≥ 100
RAMP_STEP_MS, 10, ms per 1 % ramp step; 0 = no ramp (duty_now follows the target on the next clock)

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous, active-high reset
enable  input  1  1 = run; 0 = force output off
duty_target  input  7  requested duty in %, values > 100 clamp to 100
pwm_out  output  1  registered PWM output
duty_now  output  7  current ramped duty in %
duty_applied  output  7  duty used by the current PWM period
ramping  output  1  1 while duty_now ≠ clamped target
period_tick  output  1  one-cycle pulse on the last clock of each PWM period

Behaviour:
- Reset (async, reset_p=1): all counters 0, duty_now=0, duty_applied=0, pwm_out=0, ramping=0, period_tick=0. Release mid-period restarts at period clock 0.
- Clamp: tgt = (duty_target > 100) ? 100 : duty_target. Combinational, sampled every clock.
- PWM timebase:
  - step_cnt counts 0..STEP_CLKS-1, with STEP_CLKS = PERIOD/100.
  - pct_cnt (0..99) increments when step_cnt wraps, and wraps 99→0.
  - period_tick=1 when pct_cnt=99 and step_cnt=STEP_CLKS-1.
- Duty latch: on the period_tick cycle, duty_applied ← duty_now. The new value is effective from the first clock of the next period. duty_now changing mid-period never alters the current period.
- Output: pwm_out is registered as (pct_cnt < duty_applied) && enable, so one cycle of latency from the counters.
  - duty_applied=0: pwm_out constantly 0.
  - duty_applied=100: pwm_out constantly 1, with no low gap across period boundaries.
  - duty_applied=N: exactly N*STEP_CLKS high clocks per period, starting at period clock 0 (+1 register cycle).
- Ramp tick:
  - ms divider counts SYS_FREQ/1000 clocks; a ramp counter counts RAMP_STEP_MS ms and emits a one-cycle ramp_tick.
  - Both dividers free-run from reset and are not restarted by target changes.
- Ramp step, on ramp_tick:
  - duty_now < tgt → +1
  - duty_now > tgt → −1
  - equal → hold
  - Direction is re-evaluated on every tick, so a target change mid-ramp reverses or redirects immediately with no overshoot.
  - If RAMP_STEP_MS=0: duty_now ← tgt every clock.
- ramping = (duty_now ≠ tgt), registered alongside duty_now.
- enable=0:
  - Next clock: pwm_out=0, duty_now=0, duty_applied=0.
  - The timebase keeps running.
  - Re-enable ramps up from 0.
- Simultaneous ramp_tick and period_tick: duty_applied takes the pre-tick duty_now; the stepped value is applied next period.
- All arithmetic is unsigned. Counter widths come from $clog2 of their terminal counts. duty values never leave 0..100.

Decomposition:
- Shared package fan_pkg:
  - DUTY_W=7
  - DUTY_MAX=100
  - PWM_STEPS=100
- Sub-module fan_tick_gen: parameter DIV; ports clk, reset_p, tick. Emits a one-cycle pulse every DIV clocks. Instantiated once for the ms tick; the ramp counter is kept in the top level.
- Top level holds: clamp, ramp register, pct timebase, duty latch, output register.

Test Plan:
Bench parameters: SYS_FREQ=1_000_000, PWM_FREQ=1_000 (PERIOD=1000, STEP_CLKS=10), RAMP_STEP_MS=1 unless stated.
1. Reset check: assert reset_p mid-run → all outputs 0 immediately, without waiting for a clk edge. Release, enable=1, target=30 → duty_now +1 per 1000 clocks, reaches 30 after 30 ticks, ramping falls. The next full period has exactly 300 high clocks.
2. Target 100 steady (RAMP_STEP_MS=0) → pwm_out=1 on every clock across ≥3 consecutive periods. period_tick pulses every 1000 clocks.
3. Ramp down: from steady 60, target=0 → duty_now 60→0 in 60 ticks. Each period's high count equals 10×duty_applied. Final output constant 0.
4. Clamp: duty_target=127, RAMP_STEP_MS=0 → duty_now=100, ramping=0, pwm_out constant 1.
5. Mid-period behaviour: change target 30→90 at period clock 150 with RAMP_STEP_MS=0 → the current period still has 300 high clocks; the next period has 900. Separately, drop enable at clock 150 → pwm_out=0 on the next cycle and duty_now=0.
6. Reversal: ramp 0→60, switch target to 20 when duty_now=40 → next tick gives 39, settles at 20 with no value above 40.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared constants, types and helpers for the fan speed / PWM path.
package fan_pkg;

    localparam int DUTY_W    = 7;
    localparam int PWM_STEPS = 100;

    typedef logic [DUTY_W-1:0] duty_t;

    localparam duty_t DUTY_MAX = duty_t'(100);

    typedef enum logic [1:0] {
        DIR_HOLD,
        DIR_UP,
        DIR_DOWN
    } ramp_dir_e;

    function automatic duty_t clamp_duty(input duty_t d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    // Counter width for a 0..n-1 counter; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Free-running divider: one-cycle tick on the last clock of every DIV clocks.
module fan_tick_gen
    import fan_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);

    localparam int               CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments for all registered state so every flop updates together.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)          cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + ONE;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan/LED PWM stage: soft-ramped duty, latched into the PWM only at period boundaries.
// PERIOD = SYS_FREQ/PWM_FREQ must be a multiple of 100 and at least 100.
module fan_pwm_ramp
    import fan_pkg::*;
#(
    parameter int SYS_FREQ     = 100_000_000,
    parameter int PWM_FREQ     = 10_000,
    parameter int RAMP_STEP_MS = 10
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_target,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_now,
    output logic [DUTY_W-1:0] duty_applied,
    output logic              ramping,
    output logic              period_tick
);

    localparam int PERIOD    = SYS_FREQ / PWM_FREQ;
    localparam int STEP_CLKS = PERIOD / PWM_STEPS;
    localparam int STEP_W    = cnt_width(STEP_CLKS);
    localparam int PCT_W     = cnt_width(PWM_STEPS);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CLKS - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [PCT_W-1:0]  PCT_LAST  = PCT_W'(PWM_STEPS - 1);
    localparam logic [PCT_W-1:0]  PCT_ONE   = PCT_W'(1);
    localparam duty_t             DUTY_ONE  = duty_t'(1);

    logic [STEP_W-1:0] step_cnt;
    logic [PCT_W-1:0]  pct_cnt;
    duty_t             tgt;
    duty_t             duty_next;
    ramp_dir_e         dir;
    logic              ramp_tick;

    assign tgt = clamp_duty(duty_target);

    // PWM timebase: step_cnt subdivides each 1 % slot, pct_cnt walks 0..99.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            step_cnt <= '0;
            pct_cnt  <= '0;
        end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            pct_cnt  <= (pct_cnt == PCT_LAST) ? '0 : pct_cnt + PCT_ONE;
        end else begin
            step_cnt <= step_cnt + STEP_ONE;
        end
    end

    assign period_tick = (pct_cnt == PCT_LAST) && (step_cnt == STEP_LAST);

    generate
        if (RAMP_STEP_MS == 0) begin : g_no_ramp
            assign ramp_tick = 1'b0;
        end else begin : g_ramp
            localparam int               RAMP_W    = cnt_width(RAMP_STEP_MS);
            localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_MS - 1);
            localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);

            logic              ms_tick;
            logic [RAMP_W-1:0] ramp_cnt;

            fan_tick_gen #(.DIV(SYS_FREQ / 1000)) u_ms_tick (
                .clk     (clk),
                .reset_p (reset_p),
                .tick    (ms_tick)
            );

            // Counts whole milliseconds; free-running, untouched by target changes.
            always_ff @(posedge clk or posedge reset_p) begin
                if (reset_p)                   ramp_cnt <= '0;
                else if (ms_tick) ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + RAMP_ONE;
            end

            assign ramp_tick = ms_tick && (ramp_cnt == RAMP_LAST);
        end
    endgenerate

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dir       = DIR_HOLD;
        duty_next = duty_now;
        if (duty_now < tgt)      dir = DIR_UP;
        else if (duty_now > tgt) dir = DIR_DOWN;

        if (!enable) begin
            duty_next = '0;
        end else if (RAMP_STEP_MS == 0) begin
            duty_next = tgt;
        end else if (ramp_tick) begin
            case (dir)
                DIR_UP:   duty_next = duty_now + DUTY_ONE;
                DIR_DOWN: duty_next = duty_now - DUTY_ONE;
                default:  duty_next = duty_now;
            endcase
        end
    end

    // The latch samples duty_now before this clock's ramp step lands.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            duty_now     <= '0;
            ramping      <= 1'b0;
            duty_applied <= '0;
            pwm_out      <= 1'b0;
        end else begin
            duty_now     <= duty_next;
            ramping      <= (duty_next != tgt);
            if (!enable)          duty_applied <= '0;
            else if (period_tick) duty_applied <= duty_now;
            pwm_out      <= enable && (pct_cnt < duty_applied);
        end
    end

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Bench for fan_pwm_ramp: four instances run in parallel against a cycle-level duty/PWM model.
module tb_fan_pwm_ramp;

    localparam int N      = 4;
    localparam int PERIOD = 1000;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       en  [N];
    logic [6:0] tgt [N];
    logic       pwm [N];
    logic [6:0] dn  [N];
    logic [6:0] da  [N];
    logic       rmp [N];
    logic       pt  [N];

    always #5 clk = ~clk;

    // 0: ramp 1 ms @ 1 kHz, 1: no ramp, 2: ramp 1 ms with 100 clocks per ms, 3: ramp 1 ms @ 1 kHz
    fan_pwm_ramp #(.SYS_FREQ(1_000_000), .PWM_FREQ(1_000), .RAMP_STEP_MS(1)) dut_a (
        .clk(clk), .reset_p(reset_p), .enable(en[0]), .duty_target(tgt[0]), .pwm_out(pwm[0]),
        .duty_now(dn[0]), .duty_applied(da[0]), .ramping(rmp[0]), .period_tick(pt[0]));
    fan_pwm_ramp #(.SYS_FREQ(1_000_000), .PWM_FREQ(1_000), .RAMP_STEP_MS(0)) dut_s (
        .clk(clk), .reset_p(reset_p), .enable(en[1]), .duty_target(tgt[1]), .pwm_out(pwm[1]),
        .duty_now(dn[1]), .duty_applied(da[1]), .ramping(rmp[1]), .period_tick(pt[1]));
    fan_pwm_ramp #(.SYS_FREQ(100_000), .PWM_FREQ(100), .RAMP_STEP_MS(1)) dut_d (
        .clk(clk), .reset_p(reset_p), .enable(en[2]), .duty_target(tgt[2]), .pwm_out(pwm[2]),
        .duty_now(dn[2]), .duty_applied(da[2]), .ramping(rmp[2]), .period_tick(pt[2]));
    fan_pwm_ramp #(.SYS_FREQ(1_000_000), .PWM_FREQ(1_000), .RAMP_STEP_MS(1)) dut_r (
        .clk(clk), .reset_p(reset_p), .enable(en[3]), .duty_target(tgt[3]), .pwm_out(pwm[3]),
        .duty_now(dn[3]), .duty_applied(da[3]), .ramping(rmp[3]), .period_tick(pt[3]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: clocks since reset, period position, ms-based ramp schedule.
    int ms_div  [N] = '{1000, 1000, 100, 1000};
    int ramp_ms [N] = '{1, 0, 1, 1};
    int cyc;
    int m_duty [N];
    int m_app  [N];
    bit m_pwm  [N];
    bit m_rmp  [N];

    function automatic void model_reset();
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            m_duty[i] = 0; m_app[i] = 0; m_pwm[i] = 0; m_rmp[i] = 0;
        end
    endfunction

    function automatic void model_step();
        int pos, t_c, nd, na, per_ramp;
        bit ptick, rtick, np;
        pos   = cyc % PERIOD;
        ptick = (pos == PERIOD - 1);
        for (int i = 0; i < N; i++) begin
            t_c      = (tgt[i] > 7'd100) ? 100 : int'(tgt[i]);
            per_ramp = ms_div[i] * ramp_ms[i];
            rtick    = (per_ramp != 0) ? ((cyc % (per_ramp == 0 ? 1 : per_ramp)) == per_ramp - 1) : 1'b0;
            np       = en[i] && (pos < 10 * m_app[i]);
            na       = !en[i] ? 0 : (ptick ? m_duty[i] : m_app[i]);
            if (!en[i])                        nd = 0;
            else if (ramp_ms[i] == 0)          nd = t_c;
            else if (rtick && m_duty[i] < t_c) nd = m_duty[i] + 1;
            else if (rtick && m_duty[i] > t_c) nd = m_duty[i] - 1;
            else                               nd = m_duty[i];
            m_pwm[i]  = np;
            m_app[i]  = na;
            m_duty[i] = nd;
            m_rmp[i]  = (nd != t_c);
        end
        cyc++;
    endfunction

    always @(posedge clk or posedge reset_p) begin
        if (reset_p) model_reset();
        else         model_step();
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on && !reset_p) begin
            for (int i = 0; i < N; i++)
                check($sformatf("cycle_dut%0d_c%0d", i, cyc),
                      {pwm[i], dn[i], da[i], rmp[i], pt[i]},
                      {m_pwm[i], 7'(m_duty[i]), 7'(m_app[i]), m_rmp[i], (cyc % PERIOD) == PERIOD - 1});
        end
    end

    // Counts high clocks of the next full PWM period, starting from a period-clock-0 negedge.
    task automatic count_high(input int i, output int hi, output int app, output int tk);
        int g = 0;
        hi = 0;
        tk = 0;
        while ((cyc % PERIOD) != 0 && g < 2 * PERIOD) begin
            @(negedge clk);
            g++;
        end
        app = int'(da[i]);
        repeat (PERIOD) begin
            @(negedge clk);
            hi += int'(pwm[i]);
            tk += int'(pt[i]);
        end
    endtask

    task automatic wait_dn(input int i, input int val, input int limit, output int n);
        n = 0;
        while (dn[i] !== 7'(val) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic thread_a();
        int n, hi, app, tk;
        wait_dn(0, 30, 40000, n);
        check("a_ramp_clocks", n, 30000);
        check("a_ramping_done", rmp[0], 0);
        count_high(0, hi, app, tk);
        check("a_period30_high", hi, 290);
        count_high(0, hi, app, tk);
        check("a_period31_high", hi, 300);
        en[0] = 1'b0;
        @(negedge clk);
        check("a_dis_pwm", pwm[0], 0);
        check("a_dis_duty", dn[0], 0);
        check("a_dis_applied", da[0], 0);
        repeat (499) @(negedge clk);
        en[0] = 1'b1;
        wait_dn(0, 1, 1000, n);
        check("a_reenable_first_step", n, 500);
    endtask

    task automatic thread_s();
        int hi, app, tk;
        int hi9, app9, tk9;
        count_high(1, hi, app, tk);
        check("s_period0_high", hi, 0);
        for (int p = 1; p <= 3; p++) begin
            count_high(1, hi, app, tk);
            check($sformatf("s_full_period%0d", p), hi, 1000);
            check($sformatf("s_ticks_period%0d", p), tk, 1);
        end
        tgt[1] = 7'd50;
        count_high(1, hi, app, tk);
        check("s_period4_high", hi, 1000);
        count_high(1, hi, app, tk);
        check("s_period5_high", hi, 500);
        tgt[1] = 7'd127;
        @(negedge clk);
        check("s_clamp_duty", dn[1], 100);
        check("s_clamp_ramping", rmp[1], 0);
        count_high(1, hi, app, tk);
        check("s_clamp_period_high", hi, 1000);
        tgt[1] = 7'd30;
        count_high(1, hi, app, tk);
        check("s_period8_high", hi, 1000);
        fork
            count_high(1, hi9, app9, tk9);
            begin
                repeat (150) @(negedge clk);
                tgt[1] = 7'd90;
                @(negedge clk);
                check("s_mid_duty_now", dn[1], 90);
                check("s_mid_applied_kept", da[1], 30);
            end
        join
        check("s_mid_period_high", hi9, 300);
        count_high(1, hi, app, tk);
        check("s_next_period_high", hi, 900);
        repeat (150) @(negedge clk);
        check("s_pre_disable_pwm", pwm[1], 1);
        en[1] = 1'b0;
        @(negedge clk);
        check("s_dis_pwm", pwm[1], 0);
        check("s_dis_duty", dn[1], 0);
        check("s_dis_applied", da[1], 0);
        repeat (300) @(negedge clk);
        en[1] = 1'b1;
        @(negedge clk);
        check("s_reenable_duty", dn[1], 90);
    endtask

    task automatic thread_d();
        int n, hi, app, tk;
        int exp_hi [8] = '{600, 510, 410, 310, 210, 110, 10, 0};
        wait_dn(2, 60, 8000, n);
        check("d_rampup_clocks", n, 6000);
        count_high(2, hi, app, tk);
        check("d_period6_high", hi, 590);
        tgt[2] = 7'd0;
        for (int k = 0; k < 8; k++) begin
            count_high(2, hi, app, tk);
            check($sformatf("d_down_period%0d_high", k + 7), hi, exp_hi[k]);
            check($sformatf("d_down_period%0d_applied", k + 7), app, exp_hi[k] / 10);
        end
        check("d_final_duty", dn[2], 0);
        check("d_final_ramping", rmp[2], 0);
        count_high(2, hi, app, tk);
        check("d_final_period_high", hi, 0);
    endtask

    task automatic thread_r();
        int n, g, mx;
        wait_dn(3, 40, 45000, n);
        check("r_reach40_clocks", n, 40000);
        tgt[3] = 7'd20;
        n = 0;
        while (dn[3] === 7'd40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("r_first_step_clocks", n, 1000);
        check("r_first_step_value", dn[3], 39);
        mx = int'(dn[3]);
        g  = 0;
        while (dn[3] !== 7'd20 && g < 25000) begin
            @(negedge clk);
            if (int'(dn[3]) > mx) mx = int'(dn[3]);
            g++;
        end
        check("r_settle_clocks", g, 19000);
        check("r_peak_after_reverse", mx, 39);
        check("r_settled_ramping", rmp[3], 0);
    endtask

    initial begin
        reset_p = 1'b1;
        for (int i = 0; i < N; i++) begin
            en[i]  = 1'b1;
            tgt[i] = 7'd50;
        end
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        cmp_on  = 1'b1;
        repeat (2500) @(negedge clk);
        check("pre_duty_a", dn[0], 2);
        check("pre_duty_s", dn[1], 50);
        check("pre_duty_d", dn[2], 25);
        #2 reset_p = 1'b1;
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("async_reset_dut%0d", i), {pwm[i], dn[i], da[i], rmp[i], pt[i]}, 0);
        tgt[0] = 7'd30;
        tgt[1] = 7'd100;
        tgt[2] = 7'd60;
        tgt[3] = 7'd60;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        fork
            thread_a();
            thread_s();
            thread_d();
            thread_r();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
